// File: rtl/sysref_period_monitor_if.sv
// Status/strobe bundle between the SYSREF period monitor and its consumer.
// master drives SYSREF and clear, slave (the monitor) returns measurements and lock status.
`timescale 1ns/1ps
interface sysref_period_monitor_if #(
    parameter int CNT_WIDTH = 16,
    parameter int ERR_WIDTH = 16
);
    logic                 sysref_i;
    logic                 clear_i;
    logic                 locked_o;
    logic                 sync_o;
    logic                 period_valid_o;
    logic [CNT_WIDTH-1:0] last_period_o;
    logic [CNT_WIDTH-1:0] min_period_o;
    logic [CNT_WIDTH-1:0] max_period_o;
    logic [ERR_WIDTH-1:0] err_count_o;

    modport master (
        output sysref_i, clear_i,
        input  locked_o, sync_o, period_valid_o,
        input  last_period_o, min_period_o, max_period_o, err_count_o
    );

    modport slave (
        input  sysref_i, clear_i,
        output locked_o, sync_o, period_valid_o,
        output last_period_o, min_period_o, max_period_o, err_count_o
    );
endinterface

// File: rtl/sysref_period_monitor.sv
// SYSREF edge-to-edge period measurement, lock qualification and aligned sync pulse (aclk domain).
// Optional macro SYSREF_MON_INSYNC_EN inserts a 2-flop input synchronizer (+2 cycles latency).
`timescale 1ns/1ps
module sysref_period_monitor #(
    parameter int CNT_WIDTH  = 16,
    parameter int NOM_PERIOD = 250,
    parameter int TOLERANCE  = 0,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                    aclk,
    input  logic                    reset,
    sysref_period_monitor_if.slave  mon
);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 2);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] PER_LO   = CNT_WIDTH'(NOM_PERIOD - TOLERANCE);
    localparam logic [CNT_WIDTH-1:0] PER_HI   = CNT_WIDTH'(NOM_PERIOD + TOLERANCE);
    localparam logic [ERR_WIDTH-1:0] ERR_ZERO = {ERR_WIDTH{1'b0}};
    localparam logic [ERR_WIDTH-1:0] ERR_ONE  = {{(ERR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ERR_WIDTH-1:0] ERR_MAX  = {ERR_WIDTH{1'b1}};
    localparam logic [GOOD_W-1:0]    GOOD_ZERO   = {GOOD_W{1'b0}};
    localparam logic [GOOD_W-1:0]    GOOD_ONE    = {{(GOOD_W-1){1'b0}}, 1'b1};
    localparam logic [GOOD_W-1:0]    GOOD_TARGET = GOOD_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] cnt_sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [ERR_WIDTH-1:0] err_sat_inc(input logic [ERR_WIDTH-1:0] v);
        return (v == ERR_MAX) ? v : v + ERR_ONE;
    endfunction

    state_t               state_r;
    logic                 sysref_s;
    logic                 sysref_d_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [GOOD_W-1:0]    good_cnt_r;
    logic                 late_r;
    logic                 locked_r;
    logic                 sync_r;
    logic                 period_valid_r;
    logic [CNT_WIDTH-1:0] last_period_r;
    logic [CNT_WIDTH-1:0] min_period_r;
    logic [CNT_WIDTH-1:0] max_period_r;
    logic [ERR_WIDTH-1:0] err_count_r;

    logic                 edge_s;
    logic [CNT_WIDTH-1:0] period_s;
    logic                 match_s;
    logic [GOOD_W-1:0]    good_next_s;

`ifdef SYSREF_MON_INSYNC_EN
    (* ASYNC_REG = "TRUE" *) logic sync_meta_r;
    (* ASYNC_REG = "TRUE" *) logic sync_out_r;

    // Two-stage synchronizer for a SYSREF level that is not yet in the aclk domain
    always_ff @(posedge aclk) begin
        if (reset) begin
            sync_meta_r <= 1'b0;
            sync_out_r  <= 1'b0;
        end else begin
            sync_meta_r <= mon.sysref_i;
            sync_out_r  <= sync_meta_r;
        end
    end

    assign sysref_s = sync_out_r;
`else
    assign sysref_s = mon.sysref_i;
`endif

    // The counter holds cycles since the last edge minus one, so the period is cnt+1
    assign edge_s      = sysref_s & ~sysref_d_r;
    assign period_s    = cnt_sat_inc(cnt_r);
    assign match_s     = (period_s >= PER_LO) && (period_s <= PER_HI);
    assign good_next_s = good_cnt_r + GOOD_ONE;

    // Edge history, period counter, lock FSM and registered status outputs
    always_ff @(posedge aclk) begin
        if (reset) begin
            sysref_d_r     <= 1'b0;
            state_r        <= ST_IDLE;
            cnt_r          <= CNT_ZERO;
            good_cnt_r     <= GOOD_ZERO;
            late_r         <= 1'b0;
            locked_r       <= 1'b0;
            sync_r         <= 1'b0;
            period_valid_r <= 1'b0;
            last_period_r  <= CNT_ZERO;
            min_period_r   <= CNT_MAX;
            max_period_r   <= CNT_ZERO;
            err_count_r    <= ERR_ZERO;
        end else begin
            sysref_d_r     <= sysref_s;
            sync_r         <= 1'b0;
            period_valid_r <= 1'b0;
            if (mon.clear_i) begin
                // Clear wins over a coincident edge; last_period is kept on purpose
                state_r      <= ST_IDLE;
                cnt_r        <= CNT_ZERO;
                good_cnt_r   <= GOOD_ZERO;
                late_r       <= 1'b0;
                locked_r     <= 1'b0;
                min_period_r <= CNT_MAX;
                max_period_r <= CNT_ZERO;
                err_count_r  <= ERR_ZERO;
            end else begin
                cnt_r <= edge_s ? CNT_ZERO : cnt_sat_inc(cnt_r);
                if (edge_s && (state_r != ST_IDLE)) begin
                    period_valid_r <= 1'b1;
                    last_period_r  <= period_s;
                    late_r         <= 1'b0;
                    if (period_s < min_period_r) min_period_r <= period_s;
                    if (period_s > max_period_r) max_period_r <= period_s;
                end
                case (state_r)
                    ST_IDLE: begin
                        if (edge_s) begin
                            state_r    <= ST_ACQUIRE;
                            good_cnt_r <= GOOD_ZERO;
                        end
                    end
                    ST_ACQUIRE: begin
                        if (edge_s) begin
                            if (match_s) begin
                                good_cnt_r <= good_next_s;
                                if (good_next_s == GOOD_TARGET) begin
                                    state_r  <= ST_LOCKED;
                                    locked_r <= 1'b1;
                                    sync_r   <= 1'b1;
                                end
                            end else begin
                                good_cnt_r <= GOOD_ZERO;
                            end
                        end else if (cnt_r == CNT_MAX) begin
                            state_r    <= ST_IDLE;
                            good_cnt_r <= GOOD_ZERO;
                            late_r     <= 1'b0;
                        end
                    end
                    ST_LOCKED: begin
                        if (edge_s) begin
                            if (match_s) begin
                                sync_r <= 1'b1;
                            end else begin
                                // Misplaced edge becomes the new reference for reacquisition
                                err_count_r <= err_sat_inc(err_count_r);
                                state_r     <= ST_ACQUIRE;
                                good_cnt_r  <= GOOD_ZERO;
                                locked_r    <= 1'b0;
                            end
                        end else if (cnt_r == PER_HI) begin
                            // Missing edge: count it now, the late edge itself is not counted again
                            err_count_r <= err_sat_inc(err_count_r);
                            late_r      <= 1'b1;
                            state_r     <= ST_ACQUIRE;
                            good_cnt_r  <= GOOD_ZERO;
                            locked_r    <= 1'b0;
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        good_cnt_r <= GOOD_ZERO;
                        locked_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mon.locked_o       = locked_r;
    assign mon.sync_o         = sync_r;
    assign mon.period_valid_o = period_valid_r;
    assign mon.last_period_o  = last_period_r;
    assign mon.min_period_o   = min_period_r;
    assign mon.max_period_o   = max_period_r;
    assign mon.err_count_o    = err_count_r;
endmodule

// File: tb/tb_sysref_period_monitor.sv
// Scoreboard bench for sysref_period_monitor: directed SYSREF edge trains, queued expected reports.
`timescale 1ns/1ps
module tb_sysref_period_monitor;
    localparam int CW = 16;
    localparam int EW = 2;

    typedef struct {
        int            cyc;
        logic [CW-1:0] last;
        logic [CW-1:0] mn;
        logic [CW-1:0] mx;
        logic [EW-1:0] err;
        logic          locked;
        logic          sync;
    } exp_t;

    logic aclk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_rise = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    sysref_period_monitor_if #(.CNT_WIDTH(CW), .ERR_WIDTH(EW)) bus ();

    sysref_period_monitor #(
        .CNT_WIDTH(CW), .NOM_PERIOD(250), .TOLERANCE(2), .LOCK_COUNT(4), .ERR_WIDTH(EW)
    ) dut (
        .aclk (aclk),
        .reset(reset),
        .mon  (bus)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // One-cycle SYSREF high pulse p cycles after the previous one (measured period = p)
    task automatic rise_after(input int p);
        for (int i = 1; i <= p; i++) begin
            @(negedge aclk);
            bus.sysref_i = (i == p);
        end
        last_rise = cyc;
    endtask

    task automatic edge_rep(input int p, input logic [CW-1:0] last, input logic [CW-1:0] mn,
                            input logic [CW-1:0] mx, input logic [EW-1:0] err,
                            input logic locked, input logic sync);
        exp_t e;
        rise_after(p);
        e.cyc = last_rise + 1;
        e.last = last; e.mn = mn; e.mx = mx; e.err = err; e.locked = locked; e.sync = sync;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_locked"}, 32'(bus.locked_o), 32'd0);
        check({tag, "_sync"},   32'(bus.sync_o), 32'd0);
        check({tag, "_pvalid"}, 32'(bus.period_valid_o), 32'd0);
        check({tag, "_last"},   32'(bus.last_period_o), 32'd0);
        check({tag, "_min"},    32'(bus.min_period_o), 32'd65535);
        check({tag, "_max"},    32'(bus.max_period_o), 32'd0);
        check({tag, "_err"},    32'(bus.err_count_o), 32'd0);
    endtask

    // Monitor: every period report is matched against the next queued expectation
    always @(negedge aclk) begin
        if (bus.period_valid_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_report: cyc %0d last %0d", cyc, bus.last_period_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc != mon_e.cyc || bus.last_period_o !== mon_e.last ||
                    bus.min_period_o !== mon_e.mn || bus.max_period_o !== mon_e.mx ||
                    bus.err_count_o !== mon_e.err || bus.locked_o !== mon_e.locked ||
                    bus.sync_o !== mon_e.sync) begin
                    errors++;
                    $display("FAIL period_report got/expected: cyc %0d/%0d last %0d/%0d min %0d/%0d max %0d/%0d err %0d/%0d locked %0d/%0d sync %0d/%0d",
                             cyc, mon_e.cyc, bus.last_period_o, mon_e.last, bus.min_period_o, mon_e.mn,
                             bus.max_period_o, mon_e.mx, bus.err_count_o, mon_e.err,
                             bus.locked_o, mon_e.locked, bus.sync_o, mon_e.sync);
                end
            end
        end else if (bus.sync_o === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL stray_sync: sync_o high without period report at cyc %0d", cyc);
        end
    end

    initial begin
        logic [EW-1:0] errk;
        reset = 1'b1;
        bus.sysref_i = 1'b0;
        bus.clear_i = 1'b0;
        repeat (3) @(negedge aclk);
        check_reset_state("reset");
        reset = 1'b0;

        // Acquisition: first edge silent, lock on the 5th edge
        rise_after(10);
        for (int k = 0; k < 3; k++) edge_rep(250, 16'd250, 16'd250, 16'd250, 2'd0, 1'b0, 1'b0);
        edge_rep(250, 16'd250, 16'd250, 16'd250, 2'd0, 1'b1, 1'b1);
        edge_rep(250, 16'd250, 16'd250, 16'd250, 2'd0, 1'b1, 1'b1);
        edge_rep(250, 16'd250, 16'd250, 16'd250, 2'd0, 1'b1, 1'b1);

        // Tolerance boundaries stay locked
        edge_rep(252, 16'd252, 16'd250, 16'd252, 2'd0, 1'b1, 1'b1);
        edge_rep(248, 16'd248, 16'd248, 16'd252, 2'd0, 1'b1, 1'b1);
        edge_rep(250, 16'd250, 16'd248, 16'd252, 2'd0, 1'b1, 1'b1);

        // Omitted edge: timeout one cycle after cnt reaches 252, late edge not re-counted
        for (int i = 1; i <= 500; i++) begin
            @(negedge aclk);
            bus.sysref_i = (i == 500);
            if (i == 253) check("pre_timeout_locked", 32'(bus.locked_o), 32'd1);
            if (i == 254) begin
                check("timeout_locked", 32'(bus.locked_o), 32'd0);
                check("timeout_err", 32'(bus.err_count_o), 32'd1);
            end
        end
        last_rise = cyc;
        mon_e.cyc = last_rise + 1; mon_e.last = 16'd500; mon_e.mn = 16'd248; mon_e.mx = 16'd500;
        mon_e.err = 2'd1; mon_e.locked = 1'b0; mon_e.sync = 1'b0;
        exp_q.push_back(mon_e);
        for (int k = 0; k < 3; k++) edge_rep(250, 16'd250, 16'd248, 16'd500, 2'd1, 1'b0, 1'b0);
        edge_rep(250, 16'd250, 16'd248, 16'd500, 2'd1, 1'b1, 1'b1);

        // Early edge while locked
        edge_rep(200, 16'd200, 16'd200, 16'd500, 2'd2, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) edge_rep(250, 16'd250, 16'd200, 16'd500, 2'd2, 1'b0, 1'b0);
        edge_rep(250, 16'd250, 16'd200, 16'd500, 2'd2, 1'b1, 1'b1);

        // Clear coincident with a locked edge
        for (int i = 1; i <= 250; i++) begin
            @(negedge aclk);
            bus.sysref_i = (i == 250);
            bus.clear_i = (i == 250);
        end
        @(negedge aclk);
        bus.sysref_i = 1'b0;
        bus.clear_i = 1'b0;
        check("clear_locked", 32'(bus.locked_o), 32'd0);
        check("clear_err", 32'(bus.err_count_o), 32'd0);
        check("clear_min", 32'(bus.min_period_o), 32'd65535);
        check("clear_max", 32'(bus.max_period_o), 32'd0);
        check("clear_sync", 32'(bus.sync_o), 32'd0);
        check("clear_keeps_last", 32'(bus.last_period_o), 32'd250);
        rise_after(250);
        for (int k = 0; k < 3; k++) edge_rep(250, 16'd250, 16'd250, 16'd250, 2'd0, 1'b0, 1'b0);
        edge_rep(250, 16'd250, 16'd250, 16'd250, 2'd0, 1'b1, 1'b1);

        // Error counter saturation with 2-bit width
        for (int k = 1; k <= 5; k++) begin
            errk = (k > 3) ? 2'd3 : 2'(k);
            edge_rep(200, 16'd200, 16'd200, 16'd250, errk, 1'b0, 1'b0);
            for (int j = 0; j < 3; j++) edge_rep(250, 16'd250, 16'd200, 16'd250, errk, 1'b0, 1'b0);
            edge_rep(250, 16'd250, 16'd200, 16'd250, errk, 1'b1, 1'b1);
        end

        // Reset mid-lock
        for (int i = 1; i <= 100; i++) begin
            @(negedge aclk);
            bus.sysref_i = 1'b0;
        end
        check("pre_reset_locked", 32'(bus.locked_o), 32'd1);
        reset = 1'b1;
        @(negedge aclk);
        check_reset_state("midlock_reset");
        reset = 1'b0;

        repeat (5) @(negedge aclk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sysref_period_monitor.md
Name: sysref_period_monitor

Overview:
Single-clock SYSREF qualification block in the ADC AXI4-Stream clock domain (aclk). It takes the PL-captured SYSREF level, detects rising edges and measures each edge-to-edge period in aclk cycles. It decides lock against a parametrised nominal period and tolerance, and counts missing or misplaced edges. While locked it emits a one-cycle aligned sync pulse for downstream capture/trigger logic.

Parameters:
CNT_WIDTH, 16, period counter / period output width; must hold NOM_PERIOD+TOLERANCE+1
NOM_PERIOD, 250, expected SYSREF period in aclk cycles (375 MHz / 1.5 MHz)
TOLERANCE, 0, allowed |period - NOM_PERIOD| in cycles for a match
LOCK_COUNT, 4, consecutive matching periods required to declare lock (>=1)
ERR_WIDTH, 16, error counter width

Ports:
aclk  in  1  sole clock
reset  in  1  synchronous, active-high reset
sysref_i  in  1  SYSREF level, already registered into aclk domain
clear_i  in  1  synchronous clear: state to IDLE, error counter and min/max to reset values
locked_o  out  1  high while in LOCKED
sync_o  out  1  one-cycle pulse per edge that lands in LOCKED
period_valid_o  out  1  one-cycle pulse when last_period_o updates
last_period_o  out  CNT_WIDTH  most recent measured period
min_period_o  out  CNT_WIDTH  smallest period since reset/clear
max_period_o  out  CNT_WIDTH  largest period since reset/clear
err_count_o  out  ERR_WIDTH  saturating count of bad intervals

Behaviour:
- Reset/clear values: locked_o=0, sync_o=0, period_valid_o=0, last_period_o=0, min_period_o=all-ones, max_period_o=0, err_count_o=0, state=IDLE, cnt=0, good_cnt=0, late flag=0.
- clear_i does not alter last_period_o.
- Edge: internal edge = sysref_i & ~sysref_d, where sysref_d is sysref_i delayed one cycle. All outputs are registered. sync_o and period_valid_o assert the cycle after the first high sample (latency 1).
- Period counter: cleared to 0 on an edge; otherwise increments and saturates at all-ones. Measured period = cnt+1, saturating. Edges every P cycles measure P.
- Match: NOM_PERIOD-TOLERANCE <= period <= NOM_PERIOD+TOLERANCE.
- IDLE: first edge -> ACQUIRE, good_cnt=0. No period is reported.
- ACQUIRE, edge with match: good_cnt+1. If the result equals LOCK_COUNT -> LOCKED, locked_o=1, and sync_o pulses on this edge.
- ACQUIRE, edge without match: good_cnt=0, stay in ACQUIRE. err_count_o is not incremented in ACQUIRE.
- ACQUIRE, cnt saturates: -> IDLE.
- LOCKED, matching edge: sync_o pulse, stay in LOCKED.
- LOCKED, early edge (period < NOM-TOL): err+1, -> ACQUIRE, good_cnt=0. That edge becomes the new reference.
- LOCKED, timeout (cnt == NOM_PERIOD+TOLERANCE, no edge this cycle): err+1, late flag=1, -> ACQUIRE, good_cnt=0, locked_o=0 the next cycle.
- Late edge: if the late flag is set, the edge clears the flag and does NOT increment err again. The period is still reported and still updates min/max.
- Every edge except the first after IDLE: period_valid_o pulse; last_period_o, min_period_o and max_period_o updated.
- err_count_o saturates at all-ones.
- Simultaneous events: clear_i and edge in the same cycle: clear wins and the edge is ignored (sysref_d still updates). reset overrides everything.
- Reset asserted mid-lock: outputs take reset values on the next edge of aclk.

Optional Feature:
SYSREF_MON_INSYNC_EN
- Defined: sysref_i passes through a 2-flop synchronizer (ASYNC_REG) before edge detection. All edge-related latencies grow by 2 cycles (sync_o 3 cycles after the first high input sample). Synchronizer flops reset to 0.
- Undefined: sysref_i feeds edge detection directly, latency 1.

Test Plan:
- Defaults with TOLERANCE=2, edges every 250 cycles -> period_valid_o from the 2nd edge, last_period_o=250; locked_o and first sync_o 1 cycle after the 5th edge; sync_o once per edge after that; err_count_o=0.
- Locked, one interval of 252 and one of 248 -> stays locked, last_period_o=252 then 248, min=248, max=252, no error.
- Locked, one edge omitted -> err_count_o=1 and locked_o=0 one cycle after cnt reaches 252; next edge reports 500 with err still 1; relock after 4 good periods.
- Locked, early edge at 200 -> err_count_o=1, locked_o drops the cycle after, last_period_o=200, min=200; relock after 4 more periods of 250.
- clear_i coincident with an edge while locked -> the next cycle has locked_o=0, err=0, min=all-ones, max=0 and no sync_o; the following edge only moves IDLE->ACQUIRE.
- ERR_WIDTH=2, 5 early edges while re-locking each time -> err_count_o saturates at 3. reset asserted mid-lock -> all outputs at reset values 1 cycle later.
